// File: rtl/pipeline_pkg.sv
// Shared pipeline constants and types: NOP encoding, default reset PC,
// fetch FSM encoding and the fetch queue entry.
package pipeline_pkg;

    localparam logic [31:0] NOP_INST         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_DRAIN
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch instruction queue: pointer-based FIFO with flush.
// Push and pop in the same cycle are legal even when full.
module fetch_fifo
    import pipeline_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t push_entry,
    output logic [AW:0]  count,
    output fetch_entry_t head
);

    fetch_entry_t mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // When full, the write slot is the head slot; the head is read out
    // before the edge overwrites it.
    always_ff @(posedge clk) begin
        if (push && !flush) mem[wr_ptr[AW-1:0]] <= push_entry;
    end

    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage with single outstanding imem request and queue.
// Optional FETCH_PERF_EN adds request/redirect performance counters.
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] inst_out,
    output logic        inst_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);

    localparam int          AW      = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    fetch_state_e state;
    fetch_state_e state_nx;
    logic [31:0]  fetch_pc;
    logic [31:0]  req_pc;
    logic [31:0]  last_pc;
    logic         issue;
    logic         q_push;
    logic         q_pop;
    logic [AW:0]  q_count;
    fetch_entry_t q_head;
    fetch_entry_t q_entry;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            fetch_pc <= RESET_PC;
            req_pc   <= RESET_PC;
            last_pc  <= '0;
        end else begin
            state <= state_nx;
            if (redirect_valid)
                fetch_pc <= word_align(redirect_pc);
            else if (issue)
                fetch_pc <= fetch_pc + 32'd4;
            if (issue)      req_pc  <= fetch_pc;
            if (inst_valid) last_pc <= q_head.pc;
        end
    end

    // Nothing is outstanding in FETCH, so count alone bounds the request.
    always_comb begin
        state_nx = state;
        issue    = 1'b0;
        q_push   = 1'b0;
        unique case (state)
            ST_IDLE: state_nx = ST_FETCH;
            ST_FETCH: begin
                if (!redirect_valid && q_count < DEPTH_C) begin
                    issue    = 1'b1;
                    state_nx = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (imem_rvalid) begin
                    q_push   = !redirect_valid;
                    state_nx = ST_FETCH;
                end else if (redirect_valid) begin
                    state_nx = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (imem_rvalid) state_nx = ST_FETCH;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign q_entry    = '{pc: req_pc, inst: imem_rdata};
    assign q_pop      = inst_valid && !stall && !redirect_valid;
    assign inst_valid = (q_count != '0);
    assign PC_out     = inst_valid ? q_head.pc : last_pc;
    assign inst_out   = inst_valid ? q_head.inst : NOP_INST;
    assign imem_req   = issue;
    assign imem_addr  = fetch_pc;

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (q_push),
        .pop        (q_pop),
        .flush      (redirect_valid),
        .push_entry (q_entry),
        .count      (q_count),
        .head       (q_head)
    );

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_fetch_cnt <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (issue)          perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
            if (redirect_valid) perf_flush_cnt <= perf_flush_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter: FIFO_DEPTH, 2, instruction queue entries (power of 2, >=2).
REQ-003 SHALL have port: clk  input  1  sole clock, rising-edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: stall  input  1  ID hazard hold; head not consumed.
REQ-006 SHALL have port: redirect_valid  input  1  taken branch/jump resolved downstream.
REQ-007 SHALL have port: redirect_pc  input  32  new fetch target.
REQ-008 SHALL have port: imem_req  output  1  instruction-memory read request.
REQ-009 SHALL have port: imem_addr  output  32  word-aligned request address.
REQ-010 SHALL have port: imem_rvalid  input  1  response valid, at least 1 cycle after request.
REQ-011 SHALL have port: imem_rdata  input  32  response instruction word.
REQ-012 SHALL have port: PC_out  output  32  PC of head instruction.
REQ-013 SHALL have port: inst_out  output  32  head instruction, NOP when invalid.
REQ-014 SHALL have port: inst_valid  output  1  head entry valid.

Function
REQ-015 SHALL keep at most one imem request outstanding; a request is held for exactly one cycle.
REQ-016 SHALL issue a request only when queue count + outstanding < FIFO_DEPTH and no redirect is present that cycle.
REQ-017 SHALL advance fetch_pc by 4 per issued request; 32'hFFFF_FFFC wraps to 32'h0000_0000.
REQ-018 SHALL push {fetch address, imem_rdata} into the queue on imem_rvalid, except in DRAIN.
REQ-019 SHALL present the queue head combinationally on PC_out/inst_out; inst_valid = queue non-empty.
REQ-020 SHALL pop the head when inst_valid && !stall; simultaneous push and pop on a full queue SHALL be legal and preserve order.
REQ-021 SHALL drive inst_out = 32'h0000_0013 (NOP) and keep PC_out at its last value while inst_valid = 0.
REQ-022 SHALL, on redirect_valid, flush the queue and load fetch_pc <= {redirect_pc[31:2], 2'b00} in the same edge; redirect overrides stall.
REQ-023 SHALL implement FSM states IDLE, FETCH, WAIT, DRAIN: IDLE->FETCH one cycle after reset release; FETCH->WAIT on request; WAIT->FETCH on rvalid; WAIT->DRAIN on redirect without rvalid; DRAIN->FETCH on rvalid, response discarded.
REQ-024 SHALL treat redirect in the same cycle as rvalid in WAIT as discarding that response and returning to FETCH.
REQ-025 SHALL deliver the first redirected instruction no earlier than 2 cycles after redirect_valid.

Reset
REQ-026 SHALL on rst force: state IDLE, fetch_pc = RESET_PC, queue empty, imem_req = 0, imem_addr = RESET_PC, PC_out = 0, inst_out = NOP, inst_valid = 0.
REQ-027 SHALL drop any outstanding response when reset is asserted mid-transaction; rvalid arriving in IDLE SHALL be ignored.

Configuration
REQ-028 SHALL, with FETCH_PERF_EN defined, add outputs perf_fetch_cnt[31:0] (requests issued) and perf_flush_cnt[31:0] (redirects accepted), wrapping, reset to 0; without it, neither port nor counter SHALL exist.

Structure
REQ-029 SHALL place the NOP constant, default RESET_PC and FSM state encoding in shared package pipeline_pkg.
REQ-030 SHALL implement the queue as sub-module fetch_fifo (push, pop, flush, count, head).

Verification
REQ-031 SHALL cover: reset release with 1-cycle memory -> requests at 0x0,0x4,0x8; inst_valid first high cycle 3, PC_out = 0x0.
REQ-032 SHALL cover: stall held 5 cycles with queue full -> imem_req stays 0, PC_out/inst_out unchanged, no word lost after release.
REQ-033 SHALL cover: redirect to 0x103 while WAIT -> DRAIN, old response discarded, next request addr 0x100, queue flushed.
REQ-034 SHALL cover: redirect coincident with stall = 1 -> flush still taken, inst_valid = 0 next cycle, inst_out = 0x00000013.
REQ-035 SHALL cover: fetch at 0xFFFFFFFC -> next request 0x00000000.
REQ-036 SHALL cover (FETCH_PERF_EN): 10 requests, 2 redirects -> perf_fetch_cnt = 10, perf_flush_cnt = 2.
